wb_arbiter: RTL and testbench

Write-back arbiter sharing the physical register file's `ewd` write ports among `nreq` execution-unit result producers. Each producer hands results over on a valid/ready handshake into a one-entry holding slot. Each cycle, up to `ewd` occupied slots are granted onto the `exe_bundle`/`execute` lanes feeding the register file and busy table. Results made stale by a pipeline redirect are squashed before they reach a write port.

---
 rtl/wb_arbiter_pkg.sv | 40 ++++
 rtl/wb_arbiter_pick.sv | 54 +++++
 rtl/wb_arbiter.sv | 155 +++++++++++++++
 tb/tb_wb_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the execute/write-back path.
//   exe_bundle_t : one execution result headed for a register-file write port
//   red_bundle_t : pipeline redirect (valid-flagged opid, window top, rollback)
//   opid_squash  : the single definition of "this op is stale after a redirect",
//                  shared by the register file and the write-back arbiter.
// opid[15] is the valid bit of an operation ID; only the low $clog2(opsz) bits
// take part in window distance arithmetic.
package wb_arbiter_pkg;

  localparam int OPID_W = 16;
  localparam int PRDA_W = 7;
  localparam int DATA_W = 64;

  typedef struct packed {
    logic [OPID_W-1:0] opid;
    logic [PRDA_W-1:0] prda;
    logic [DATA_W-1:0] data;
  } exe_bundle_t;

  typedef struct packed {
    logic [OPID_W-1:0] opid;
    logic [OPID_W-1:0] topid;
    logic              rollback;
  } red_bundle_t;

  // An op is stale when a rollback is in flight, or when it sits strictly
  // younger than the redirecting op, measured as distance from the window top.
  function automatic logic opid_squash(red_bundle_t red, logic [15:0] opid, int opsz);
    logic [15:0] mask;
    logic [15:0] d_op;
    logic [15:0] d_red;
    logic [16:0] lim;
    mask  = 16'(opsz - 1);
    d_op  = (opid - red.topid) & mask;
    d_red = (red.opid - red.topid) & mask;
    lim   = {1'b0, d_red} + 17'd1;
    return red.rollback | (red.opid[15] & opid[15] & ({1'b0, d_op} >= lim));
  endfunction

endpackage

// File: rtl/wb_arbiter_pick.sv
// wb_pick: rotating-priority picker.
//   req      : request vector
//   start    : index with highest priority; priority falls upward with wrap
//   gnt_vld  : lane l holds a grant
//   gnt_idx  : request index placed on lane l (lanes filled in scan order)
//   gnt_mask : one-hot-per-request mask of everything granted
//   last_idx : index of the last grant in scan order (start when none)
//   any      : at least one grant
module wb_pick #(
  parameter int n = 6,
  parameter int k = 4,
  localparam int IW = (n > 1) ? $clog2(n) : 1
) (
  input  logic [n-1:0]         req,
  input  logic [IW-1:0]        start,
  output logic [k-1:0]         gnt_vld,
  output logic [k-1:0][IW-1:0] gnt_idx,
  output logic [n-1:0]         gnt_mask,
  output logic [IW-1:0]        last_idx,
  output logic                 any
);

  int            cnt;
  logic [IW:0]   sum;
  logic [IW-1:0] idx;
  logic          take;

  // Walk all requests from start with wrap; the first k hits fill lanes in order
  always_comb begin
    gnt_vld  = '0;
    gnt_idx  = '0;
    gnt_mask = '0;
    last_idx = start;
    any      = 1'b0;
    cnt      = 0;
    sum      = '0;
    idx      = '0;
    take     = 1'b0;
    for (int off = 0; off < n; off++) begin
      sum  = {1'b0, start} + (IW+1)'(off);
      idx  = (sum >= (IW+1)'(n)) ? IW'(sum - (IW+1)'(n)) : IW'(sum);
      take = req[idx] & (cnt < k);
      for (int l = 0; l < k; l++) begin
        gnt_vld[l] = gnt_vld[l] | (take & (cnt == l));
        gnt_idx[l] = (take && (cnt == l)) ? idx : gnt_idx[l];
      end
      gnt_mask[idx] = gnt_mask[idx] | take;
      last_idx      = take ? idx : last_idx;
      any           = any | take;
      cnt           = cnt + (take ? 1 : 0);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares ewd register-file write lanes among nreq result producers.
//   clk, rst            : clock, asynchronous active-high reset
//   req_bundle/valid    : producer results offered into one-entry holding slots
//   req_ready           : slot empty or being granted this cycle (refill)
//   red_bundle          : redirect; stale slots are masked now and cleared at the edge
//   exe_bundle/execute  : granted results, lanes 0..ewd-1, unused lanes all-zero
// Build option WBARB_AGE_EN: pick the oldest ops (distance from red_bundle.topid)
// instead of round-robin; lanes then run oldest first and no rr pointer exists.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int nreq  = 6,
  parameter int ewd   = 4,
  parameter int opsz  = 64,
  parameter int prnum = 96
) (
  input  logic                   clk,
  input  logic                   rst,
  input  exe_bundle_t [nreq-1:0] req_bundle,
  input  logic [nreq-1:0]        req_valid,
  output logic [nreq-1:0]        req_ready,
  input  red_bundle_t            red_bundle,
  output exe_bundle_t [ewd-1:0]  exe_bundle,
  output logic [ewd-1:0]         execute
);

  localparam int IW  = (nreq > 1) ? $clog2(nreq) : 1;
  localparam int PRW = $clog2(prnum);
  localparam logic [PRDA_W-1:0] PRDA_MASK = PRDA_W'((64'd1 << PRW) - 64'd1);

  exe_bundle_t [nreq-1:0] slot_r;
  logic [nreq-1:0]        occ_r;

  logic [nreq-1:0]        squash_s;
  logic [nreq-1:0]        cand_s;
  logic [nreq-1:0]        gnt_s;
  logic [ewd-1:0]         lane_vld_s;
  logic [ewd-1:0][IW-1:0] lane_idx_s;
  logic [nreq-1:0]        load_s;
  exe_bundle_t [nreq-1:0] load_b_s;

  // Slots made stale by the live redirect drop out of selection this cycle
  always_comb begin
    squash_s = '0;
    for (int i = 0; i < nreq; i++) begin
      squash_s[i] = occ_r[i] & opid_squash(red_bundle, slot_r[i].opid, opsz);
    end
    cand_s = occ_r & ~squash_s;
  end

`ifdef WBARB_AGE_EN
  localparam int DW = (opsz > 1) ? $clog2(opsz) : 1;

  logic [nreq-1:0][DW-1:0] dist_s;
  logic [15:0]             diff_s;
  int                      rank_s;
  logic                    hit_s;

  // Age selection: a candidate's rank is how many candidates are older;
  // ranks 0..ewd-1 map straight onto lanes, so lanes come out oldest first
  always_comb begin
    lane_vld_s = '0;
    lane_idx_s = '0;
    gnt_s      = '0;
    dist_s     = '0;
    diff_s     = '0;
    rank_s     = 0;
    hit_s      = 1'b0;
    for (int i = 0; i < nreq; i++) begin
      diff_s    = slot_r[i].opid - red_bundle.topid;
      dist_s[i] = diff_s[DW-1:0];
    end
    for (int i = 0; i < nreq; i++) begin
      rank_s = 0;
      for (int j = 0; j < nreq; j++) begin
        rank_s = rank_s + ((cand_s[j] && (dist_s[j] < dist_s[i])) ? 1 : 0);
      end
      for (int l = 0; l < ewd; l++) begin
        hit_s         = cand_s[i] & (rank_s == l);
        lane_vld_s[l] = lane_vld_s[l] | hit_s;
        lane_idx_s[l] = hit_s ? IW'(i) : lane_idx_s[l];
        gnt_s[i]      = gnt_s[i] | hit_s;
      end
    end
  end
`else
  logic [IW-1:0] rr_r;
  logic [IW-1:0] pick_last_s;
  logic          pick_any_s;

  wb_pick #(
    .n (nreq),
    .k (ewd)
  ) u_pick (
    .req      (cand_s),
    .start    (rr_r),
    .gnt_vld  (lane_vld_s),
    .gnt_idx  (lane_idx_s),
    .gnt_mask (gnt_s),
    .last_idx (pick_last_s),
    .any      (pick_any_s)
  );

  // Round-robin pointer moves just past the last slot granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_r <= '0;
    end else if (pick_any_s) begin
      rr_r <= (pick_last_s == IW'(nreq - 1)) ? '0 : pick_last_s + IW'(1);
    end
  end
`endif

  // Ready allows refill of a slot being granted; stale incoming ops are accepted but not loaded
  always_comb begin
    req_ready = '0;
    load_s    = '0;
    load_b_s  = '0;
    for (int i = 0; i < nreq; i++) begin
      req_ready[i]     = ~rst & (~occ_r[i] | gnt_s[i]);
      load_s[i]        = req_valid[i] & req_ready[i] & req_bundle[i].opid[15]
                       & ~opid_squash(red_bundle, req_bundle[i].opid, opsz);
      load_b_s[i]      = req_bundle[i];
      load_b_s[i].prda = req_bundle[i].prda & PRDA_MASK;
    end
  end

  // Holding slots: load on handshake, otherwise empty when granted or squashed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_r  <= '0;
      slot_r <= '0;
    end else begin
      for (int i = 0; i < nreq; i++) begin
        if (load_s[i]) begin
          occ_r[i]  <= 1'b1;
          slot_r[i] <= load_b_s[i];
        end else if (gnt_s[i] | squash_s[i]) begin
          occ_r[i]  <= 1'b0;
        end
      end
    end
  end

  // Lane drive straight from the slot registers; idle lanes are all-zero
  always_comb begin
    execute    = '0;
    exe_bundle = '0;
    for (int l = 0; l < ewd; l++) begin
      execute[l]    = lane_vld_s[l];
      exe_bundle[l] = lane_vld_s[l] ? slot_r[lane_idx_s[l]] : '0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter (nreq=6, ewd=4, opsz=64, prnum=96).
// Stimulus pushes the hand-computed lane results it expects; a negedge monitor
// pops one entry per live lane and checks that idle lanes are all-zero.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic                clk;
  logic                rst;
  exe_bundle_t [5:0]   req_bundle;
  logic [5:0]          req_valid;
  logic [5:0]          req_ready;
  red_bundle_t         red_bundle;
  exe_bundle_t [3:0]   exe_bundle;
  logic [3:0]          execute;

  int n_chk;
  int n_fail;

  typedef struct {
    int          lane;
    logic [15:0] opid;
    logic [6:0]  prda;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];

  wb_arbiter #(
    .nreq  (6),
    .ewd   (4),
    .opsz  (64),
    .prnum (96)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_bundle (req_bundle),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .red_bundle (red_bundle),
    .exe_bundle (exe_bundle),
    .execute    (execute)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [127:0] act, logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exe_bundle_t mk(int num, int prda);
    exe_bundle_t b;
    b.opid = 16'h8000 | 16'(num);
    b.prda = 7'(prda);
    b.data = {48'hDA7A_0000_0000, 16'(num)};
    return b;
  endfunction

  task automatic push(int lane, int num, int prda);
    exp_t e;
    e.lane = lane;
    e.opid = 16'h8000 | 16'(num);
    e.prda = 7'(prda);
    e.data = {48'hDA7A_0000_0000, 16'(num)};
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Monitor: every live lane must match the next expected result, in lane order
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (execute[k]) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_result lane=%0d opid=%0h required=none", k, exe_bundle[k].opid);
          end else begin
            e = sb.pop_front();
            chk("lane_index", 128'(k), 128'(e.lane));
            chk("lane_opid", 128'(exe_bundle[k].opid), 128'(e.opid));
            chk("lane_prda", 128'(exe_bundle[k].prda), 128'(e.prda));
            chk("lane_data", 128'(exe_bundle[k].data), 128'(e.data));
          end
        end else begin
          chk("idle_lane_zero", 128'(exe_bundle[k]), 128'd0);
        end
      end
    end
  end

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    rst        = 1'b1;
    req_valid  = 6'b0;
    req_bundle = '0;
    red_bundle = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 128'(req_ready), 128'h0);
    chk("reset_execute", 128'(execute), 128'h0);
    rst = 1'b0;
    at_neg();
    chk("ready_after_release", 128'(req_ready), 128'h3f);

    // Slots 0,2,5 -> lanes 0..2 in slot order
    step();
    req_bundle[0] = mk(1, 3);
    req_bundle[2] = mk(2, 7);
    req_bundle[5] = mk(3, 9);
    req_valid     = 6'b100101;
    push(0, 1, 3);
    push(1, 2, 7);
    push(2, 3, 9);
    step();
    req_valid = 6'b0;
    at_neg();
    chk("sparse_execute", 128'(execute), 128'h7);
    step();

`ifndef WBARB_AGE_EN
    // All six slots kept full: grants {0,1,2,3}, {4,5,0,1}, {2,3,4,5}
    for (int i = 0; i < 6; i++) req_bundle[i] = mk(10 + i, 10 + i);
    req_valid = 6'h3f;
    push(0, 10, 10); push(1, 11, 11); push(2, 12, 12); push(3, 13, 13);
    push(0, 14, 14); push(1, 15, 15);
    step();
    for (int i = 0; i < 4; i++) req_bundle[i] = mk(20 + i, 20 + i);
    req_valid = 6'h0f;
    push(2, 20, 20); push(3, 21, 21); push(0, 22, 22); push(1, 23, 23);
    at_neg();
    chk("rr_c1_ready", 128'(req_ready), 128'h0f);
    chk("rr_c1_execute", 128'(execute), 128'hf);
    step();
    req_bundle[0] = mk(30, 30);
    req_bundle[1] = mk(31, 31);
    req_bundle[4] = mk(34, 34);
    req_bundle[5] = mk(35, 35);
    req_valid     = 6'h33;
    push(2, 34, 34); push(3, 35, 35); push(0, 30, 30); push(1, 31, 31);
    at_neg();
    chk("rr_c2_ready", 128'(req_ready), 128'h33);
    chk("rr_c2_execute", 128'(execute), 128'hf);
    step();
    req_valid = 6'b0;
    at_neg();
    chk("rr_c3_ready", 128'(req_ready), 128'h3c);
    chk("rr_c3_execute", 128'(execute), 128'hf);
    step();
    at_neg();
    chk("rr_c4_ready", 128'(req_ready), 128'h3f);
    chk("rr_c4_execute", 128'(execute), 128'h3);
    step();
`endif

    // Redirect topid=10, red.opid=20: opid 15 survives, 25 is cleared,
    // incoming 30 is accepted and dropped, incoming 12 is loaded
    req_bundle[1] = mk(15, 15);
    req_bundle[3] = mk(25, 25);
    req_valid     = 6'h0a;
    push(0, 15, 15);
    step();
    red_bundle.opid     = 16'h8014;
    red_bundle.topid    = 16'd10;
    red_bundle.rollback = 1'b0;
    req_bundle[0] = mk(12, 12);
    req_bundle[4] = mk(30, 30);
    req_valid     = 6'h11;
    push(0, 12, 12);
    at_neg();
    chk("squash_execute", 128'(execute), 128'h1);
    chk("squash_ready", 128'(req_ready), 128'h37);
    step();
    red_bundle = '0;
    req_valid  = 6'b0;
    at_neg();
    chk("post_squash_execute", 128'(execute), 128'h1);
    chk("post_squash_ready", 128'(req_ready), 128'h3f);
    step();
    at_neg();
    chk("squash_drained", 128'(execute), 128'h0);
    step();

    // Rollback with four occupied slots
    for (int i = 0; i < 4; i++) req_bundle[i] = mk(40 + i, 40 + i);
    req_valid = 6'h0f;
    step();
    req_valid           = 6'b0;
    red_bundle.rollback = 1'b1;
    at_neg();
    chk("rollback_execute", 128'(execute), 128'h0);
    chk("rollback_ready", 128'(req_ready), 128'h30);
    step();
    red_bundle = '0;
    at_neg();
    chk("post_rollback_ready", 128'(req_ready), 128'h3f);
    chk("post_rollback_execute", 128'(execute), 128'h0);
    step();

    // Back-to-back refill of slot 2: one result per cycle, no bubble
    for (int c = 0; c < 5; c++) begin
      if (c < 4) begin
        req_bundle[2] = mk(50 + c, 50 + c);
        req_valid     = 6'h04;
        push(0, 50 + c, 50 + c);
      end else begin
        req_valid = 6'b0;
      end
      at_neg();
      chk("b2b_execute", 128'(execute), (c == 0) ? 128'h0 : 128'h1);
      chk("b2b_ready", 128'(req_ready), 128'h3f);
      step();
    end
    at_neg();
    chk("b2b_done", 128'(execute), 128'h0);
    step();

`ifdef WBARB_AGE_EN
    // Age order from topid=60: 61, 62, 0, 1 then 3
    red_bundle.topid = 16'd60;
    req_bundle[0] = mk(62, 62);
    req_bundle[1] = mk(1, 1);
    req_bundle[2] = mk(61, 61);
    req_bundle[3] = mk(3, 3);
    req_bundle[4] = mk(0, 0);
    req_valid     = 6'h1f;
    push(0, 61, 61); push(1, 62, 62); push(2, 0, 0); push(3, 1, 1);
    push(0, 3, 3);
    step();
    req_valid = 6'b0;
    at_neg();
    chk("age_execute", 128'(execute), 128'hf);
    step();
    at_neg();
    chk("age_tail_execute", 128'(execute), 128'h1);
    step();
    red_bundle = '0;
`endif

    // Asynchronous reset discards a held result at once
    req_bundle[3] = mk(70, 70);
    req_valid     = 6'h08;
    step();
    req_valid = 6'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_execute", 128'(execute), 128'h0);
    chk("async_rst_ready", 128'(req_ready), 128'h0);
    step();
    rst = 1'b0;
    at_neg();
    chk("after_async_execute", 128'(execute), 128'h0);
    chk("after_async_ready", 128'(req_ready), 128'h3f);

    repeat (2) step();
    chk("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
